pipe_hazard_ctrl: RTL

- Parametrised pipeline control unit for the in-order pcpu family. It replaces the fixed hand-coded load-stall and forwarding checks with a per-stage write scoreboard.
- Sits beside ID. It tracks in-flight destination writes across DEPTH downstream stages (EX..WB) and generates the following:
  - the stall and flush controls
  - the forward selects for both source operands
  - the idle/run/drain run-state, with a drain phase
  - a saturating stall counter

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage write scoreboard driving stall, flush and
// operand forward selects for the in-order pcpu, plus an idle/run/drain run-state.
module pipe_hazard_ctrl #(
  parameter int NREG       = 8,
  parameter int AW         = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = 2,
  parameter int CW         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          halt_wb,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic          id_rs_used,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_we,
  input  logic          id_is_load,
  input  logic          branch_taken,
  output logic          running,
  output logic          stall,
  output logic          flush,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic [CW-1:0] stall_count
);

  localparam int DCW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DCW-1:0]       drainCnt_q, drainCnt_d;

  // Scoreboard: index i holds the instruction now in stage i+1.
  logic [DEPTH-1:0]         sbValid_q;
  logic [DEPTH-1:0][AW-1:0] sbRd_q;
  logic [DEPTH-1:0]         sbLoad_q;

  logic                 inRun;
  logic                 hazA, hazB;
  logic                 issue;

  // Returns {hazard, select}; the youngest matching producer wins.
  function automatic logic [SW:0] lookup(
    input logic [AW-1:0]            src,
    input logic                     used,
    input logic [DEPTH-1:0]         v,
    input logic [DEPTH-1:0][AW-1:0] rd,
    input logic [DEPTH-1:0]         ld
  );
    logic [SW-1:0] sel;
    logic          haz;
    sel = '0;
    haz = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && (src != '0) && (int'(src) < NREG) && v[i] && (rd[i] == src)) begin
        if (!ld[i] || ((i + 1) >= LOAD_STAGE)) begin
          sel = SW'(i + 1);
          haz = 1'b0;
        end else begin
          sel = '0;
          haz = 1'b1;
        end
      end
    end
    return {haz, sel};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      IDLE: begin
        if (enable && start) state_d = RUN;
      end
      RUN: begin
        if (halt_wb) begin
          state_d = IDLE;
        end else if (!enable) begin
          state_d    = DRAIN;
          drainCnt_d = DCW'(DEPTH);
        end
      end
      DRAIN: begin
        // Enable coming back does not cut the drain short.
        if (halt_wb || (drainCnt_q <= DCW'(1))) begin
          state_d    = IDLE;
          drainCnt_d = '0;
        end else begin
          drainCnt_d = drainCnt_q - DCW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        drainCnt_d = '0;
      end
    endcase
  end

  always_comb begin
    running = (state_q != IDLE);
    inRun   = (state_q == RUN);
  end

  always_comb begin
    {hazA, fwd_a} = lookup(id_rs, id_rs_used, sbValid_q, sbRd_q, sbLoad_q);
    {hazB, fwd_b} = lookup(id_rt, id_rt_used, sbValid_q, sbRd_q, sbLoad_q);
    flush = running && branch_taken;
    stall = inRun && id_valid && (hazA || hazB) && !branch_taken;
    issue = inRun && id_valid && id_we && (id_rd != '0) && !stall && !flush;
  end

  // Stalled or flushed ID slots enter the pipe as bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbValid_q <= '0;
      sbRd_q    <= '0;
      sbLoad_q  <= '0;
    end else if (running) begin
      sbValid_q <= {sbValid_q[DEPTH-2:0], issue};
      sbRd_q    <= {sbRd_q[DEPTH-2:0], id_rd};
      sbLoad_q  <= {sbLoad_q[DEPTH-2:0], id_is_load};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CW{1'b1}})) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule
